// File: rtl/par_mux_pkg.sv
// par_mux_pkg: state encoding and default sizing shared by arbiter, datapath and tester.
package par_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam int BUS_SIZE_DEF  = 16;
    localparam int NUM_REQ_DEF   = 2;
    localparam int FRAME_LEN_DEF = 4;
    localparam int TIMEOUT_DEF   = 8;
    localparam int STALL_W       = 8;

endpackage

// File: rtl/par_mux_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first valid requester after last_grant.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      pick_idx
);

    localparam int SW = IW + 1;

    logic          found;
    logic [SW-1:0] sum;
    logic [IW-1:0] cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        sum      = '0;
        cand     = '0;
        // offset 1..NUM_REQ wraps so last_grant itself is considered last
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum  = {1'b0, last_grant} + SW'(k);
            cand = (sum >= SW'(NUM_REQ)) ? IW'(sum - SW'(NUM_REQ)) : IW'(sum);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
        if (found) pick[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/par_mux_arbiter.sv
// par_mux_arbiter: round-robin frame arbiter forwarding one requester's words with a stall watchdog.
module par_mux_arbiter
    import par_mux_pkg::*;
#(
    parameter int BUS_SIZE  = BUS_SIZE_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*BUS_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [BUS_SIZE-1:0]         out_data,
    input  logic                        out_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        frame_done,
    output logic                        abort_error,
    output logic [1:0]                  state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(FRAME_LEN + 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_q, last_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 done_q, done_d;
    logic [NUM_REQ-1:0]   pick;
    logic [IW-1:0]        pick_idx;
    logic                 owner_valid, xfer, beat;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req_valid (req_valid),
        .last_grant(last_q),
        .pick      (pick),
        .pick_idx  (pick_idx)
    );

    assign owner_valid = req_valid[owner_q];
    assign xfer        = (state_q == ST_XFER);
    assign out_valid   = xfer & owner_valid;
    assign beat        = out_valid & out_ready;
    assign req_ready   = (xfer && out_ready) ? (NUM_REQ'(1) << owner_q) : '0;
    // owner_q survives the frame, so the idle bus shows the last owner's lane
    assign out_data    = req_data[owner_q*BUS_SIZE +: BUS_SIZE];
    assign grant       = grant_q;
    assign frame_done  = done_q;
    assign abort_error = (state_q == ST_ABORT);
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        stall_d = stall_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                beat_d  = '0;
                stall_d = '0;
                if (|req_valid) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    stall_d = '0;
                    beat_d  = beat_q + BW'(1);
                    if (beat_q == BW'(FRAME_LEN - 1)) begin
                        last_d  = owner_q;
                        grant_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (!owner_valid) begin
                    if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        last_d  = owner_q;
                        grant_d = '0;
                        state_d = ST_ABORT;
                    end else begin
                        stall_d = stall_q + {{(STALL_W-1){1'b0}}, stall_q != '1};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
            stall_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_par_mux_arbiter.sv
// tb_par_mux_arbiter: directed self-checking bench for the round-robin frame arbiter.
module tb_par_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [1:0]  grant;
    logic        frame_done;
    logic        abort_error;
    logic [1:0]  state;

    int passed = 0;
    int total  = 0;

    par_mux_arbiter #(.BUS_SIZE(16), .NUM_REQ(2), .FRAME_LEN(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .grant      (grant),
        .frame_done (frame_done),
        .abort_error(abort_error),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt();
        reset = 1'b0;
        req_valid = 2'b00;
        nxt();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 2'b11;
        req_data = 32'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            chk("rst_grant", {30'd0, grant}, 32'h0);
            chk("rst_valid", {31'd0, out_valid}, 32'h0);
            chk("rst_state", {30'd0, state}, 32'h0);
        end
        // single frame from requester 0
        nxt();
        reset = 1'b1;
        req_valid = 2'b00;
        #1 chk("sf_idle", {30'd0, state}, 32'h0);
        nxt();
        req_valid = 2'b01;
        req_data[15:0] = 16'hFFF0;
        #1 chk("sf_nogrant", {30'd0, grant}, 32'h0);
        nxt(); #1;
        chk("sf_grant", {30'd0, grant}, 32'h1);
        chk("sf_ready", {30'd0, req_ready}, 32'h1);
        chk("sf_w0", {16'd0, out_data}, 32'hFFF0);
        nxt(); req_data[15:0] = 16'hFDD1;
        #1 chk("sf_w1", {16'd0, out_data}, 32'hFDD1);
        nxt(); req_data[15:0] = 16'hFEE2;
        #1 chk("sf_w2", {16'd0, out_data}, 32'hFEE2);
        nxt(); req_data[15:0] = 16'hFCC3;
        #1 chk("sf_w3", {16'd0, out_data}, 32'hFCC3);
        chk("sf_nodone", {31'd0, frame_done}, 32'h0);
        nxt(); req_valid = 2'b00;
        #1 chk("sf_done", {31'd0, frame_done}, 32'h1);
        chk("sf_state", {30'd0, state}, 32'h0);
        chk("sf_grant0", {30'd0, grant}, 32'h0);
        nxt(); #1 chk("sf_done_pulse", {31'd0, frame_done}, 32'h0);
        // fairness: both valid continuously
        do_reset();
        req_valid = 2'b11;
        req_data = 32'hB000_A000;
        #1 chk("fa_idle0", {30'd0, state}, 32'h0);
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 4; b++) begin
                nxt(); #1;
                chk("fa_grant", {30'd0, grant}, (f % 2) ? 32'h2 : 32'h1);
                chk("fa_ready", {30'd0, req_ready}, (f % 2) ? 32'h2 : 32'h1);
                chk("fa_data", {16'd0, out_data}, (f % 2) ? 32'hB000 : 32'hA000);
            end
            nxt(); #1;
            chk("fa_gap", {30'd0, state}, 32'h0);
            chk("fa_done", {31'd0, frame_done}, 32'h1);
        end
        req_valid = 2'b00;
        // backpressure on requester 0 (last owner was 1)
        nxt();
        req_valid = 2'b01;
        req_data[15:0] = 16'hC000;
        nxt(); #1 chk("bp_w0", {16'd0, out_data}, 32'hC000);
        nxt(); req_data[15:0] = 16'hC001;
        #1 chk("bp_w1", {16'd0, out_data}, 32'hC001);
        nxt(); req_data[15:0] = 16'hC002;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) nxt();
            #1;
            chk("bp_hold", {16'd0, out_data}, 32'hC002);
            chk("bp_noabort", {31'd0, abort_error}, 32'h0);
            chk("bp_state", {30'd0, state}, 32'h1);
        end
        nxt(); out_ready = 1'b1;
        #1 chk("bp_resume", {30'd0, req_ready}, 32'h1);
        nxt(); req_data[15:0] = 16'hC003;
        #1 chk("bp_w3", {16'd0, out_data}, 32'hC003);
        nxt(); req_valid = 2'b00;
        #1 chk("bp_done", {31'd0, frame_done}, 32'h1);
        // watchdog: requester 0 dies after 2 beats
        do_reset();
        req_valid = 2'b11;
        nxt(); #1 chk("wd_grant", {30'd0, grant}, 32'h1);
        nxt();
        nxt(); req_valid = 2'b10;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) nxt();
            #1;
            chk("wd_stall_state", {30'd0, state}, 32'h1);
            chk("wd_noabort", {31'd0, abort_error}, 32'h0);
            chk("wd_nvalid", {31'd0, out_valid}, 32'h0);
        end
        nxt(); #1;
        chk("wd_abort", {31'd0, abort_error}, 32'h1);
        chk("wd_abort_state", {30'd0, state}, 32'h2);
        chk("wd_abort_grant", {30'd0, grant}, 32'h0);
        nxt(); #1;
        chk("wd_abort_pulse", {31'd0, abort_error}, 32'h0);
        chk("wd_idle", {30'd0, state}, 32'h0);
        chk("wd_nodone", {31'd0, frame_done}, 32'h0);
        nxt(); #1 chk("wd_next_grant", {30'd0, grant}, 32'h2);
        // mid-frame reset after beat 1 of requester 1
        nxt(); reset = 1'b0;
        #1;
        chk("mr_grant", {30'd0, grant}, 32'h0);
        chk("mr_state", {30'd0, state}, 32'h0);
        chk("mr_valid", {31'd0, out_valid}, 32'h0);
        chk("mr_ready", {30'd0, req_ready}, 32'h0);
        chk("mr_done", {31'd0, frame_done}, 32'h0);
        chk("mr_abort", {31'd0, abort_error}, 32'h0);
        nxt(); reset = 1'b1;
        req_valid = 2'b11;
        nxt(); #1 chk("mr_first", {30'd0, grant}, 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
